// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared sizes and encode/decode helpers for the request select path
package enc_pkg;

    localparam int N = 8;
    localparam int W = 3;

    // Highest set index wins; an all-zero vector maps to 0.
    function automatic logic [W-1:0] prio8(input logic [N-1:0] vec);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
        end
        return idx;
    endfunction

    function automatic logic [N-1:0] onehot3(input logic [W-1:0] c);
        return N'(1) << c;
    endfunction

endpackage

// File: rtl/prio_enc_8.sv
// rtl/prio_enc_8.sv - combinational 8-to-3 priority encoder with an any-set flag
module prio_enc_8
    import enc_pkg::*;
(
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    assign idx = prio8(vec);
    assign any = |vec;

endmodule

// File: rtl/encoder_83_req.sv
// rtl/encoder_83_req.sv - registered 8-to-3 priority request concentrator with valid/ready output
module encoder_83_req
    import enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         e,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] overrun,
    output logic         busy
);

    if (N != 8 || W != 3) begin : g_size_check
        $error("encoder_83_req is fixed at N=8, W=3");
    end

    logic [N-1:0] pending;
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic [N-1:0] cand;
    logic         ack;
    logic [W-1:0] cand_idx;
    logic         cand_any;

    assign set  = req & {N{e}};
    assign ack  = valid & ready;
    assign clr  = ack ? onehot3(code) : '0;
    // Fresh requests stay out of cand so they surface one cycle after capture.
    assign cand = pending & ~clr;

    prio_enc_8 u_prio (
        .vec (cand),
        .idx (cand_idx),
        .any (cand_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            overrun <= '0;
            valid   <= 1'b0;
            code    <= '0;
        end else begin
            // Set after clear: a re-request on the acked index stays pending.
            pending <= cand | set;
            overrun <= set & pending & ~clr;
            if (!valid || ack) begin
                valid <= cand_any;
                if (cand_any) code <= cand_idx;
            end
        end
    end

    assign busy = (|pending) | valid;

endmodule

// File: tb/tb_encoder_83_req.sv
// tb/tb_encoder_83_req.sv - scoreboard bench for encoder_83_req against a behavioural model
module tb_encoder_83_req;

    logic       clk = 1'b0;
    logic       rst;
    logic       e;
    logic [7:0] req;
    logic [2:0] code;
    logic       valid;
    logic       ready;
    logic [7:0] overrun;
    logic       busy;

    encoder_83_req dut (
        .clk     (clk),
        .rst     (rst),
        .e       (e),
        .req     (req),
        .code    (code),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [2:0] c;
        logic       b;
        logic [7:0] ov;
    } snap_t;

    snap_t state_q[$];
    int    acc_log[$];
    int    tests = 0;
    int    fails = 0;

    // Behavioural model: a set of waiting line numbers plus the presented one.
    bit m_pend[8];
    bit m_valid;
    int m_code;
    bit m_ov[8];

    task automatic model_step(input bit r, input bit en, input logic [7:0] rq, input bit rd);
        bit ack;
        bit cand[8];
        bit found;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 1'b0;
                m_ov[i]   = 1'b0;
            end
            m_valid = 1'b0;
            m_code  = 0;
            return;
        end
        ack = m_valid && rd;
        for (int i = 0; i < 8; i++) begin
            bit s;
            bit c;
            s = en && rq[i];
            c = ack && (i == m_code);
            m_ov[i]   = s && m_pend[i] && !c;
            cand[i]   = m_pend[i] && !c;
            m_pend[i] = cand[i] || s;
        end
        if (!m_valid || ack) begin
            found = 1'b0;
            for (int i = 7; i >= 0; i--) begin
                if (cand[i] && !found) begin
                    m_code = i;
                    found  = 1'b1;
                end
            end
            m_valid = found;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        bit any;
        any = m_valid;
        for (int i = 0; i < 8; i++) begin
            any     = any || m_pend[i];
            s.ov[i] = m_ov[i];
        end
        s.v = m_valid;
        s.c = 3'(m_code);
        s.b = any;
        return s;
    endfunction

    task automatic cyc(input bit r, input bit en, input logic [7:0] rq, input bit rd);
        rst   = r;
        e     = en;
        req   = rq;
        ready = rd;
        model_step(r, en, rq, rd);
        @(posedge clk);
        #1;
        state_q.push_back(model_snap());
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 8'h00, rd);
    endtask

    // Expected accept order packed as one hex digit per code, oldest first.
    task automatic check_log(input string name, input int n, input logic [31:0] exp);
        bit ok;
        ok = (acc_log.size() == n);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                if (acc_log[i] != int'(exp[4*(n-1-i) +: 4])) ok = 1'b0;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: accepted %0d codes %p, required %0d codes %h", name, acc_log.size(), acc_log, n, exp);
        end
        acc_log.delete();
    endtask

    initial begin : monitor
        snap_t exp;
        snap_t got;
        forever begin
            @(negedge clk);
            if (state_q.size() > 0) begin
                exp = state_q.pop_front();
                got = {valid, code, busy, overrun};
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL state @%0t: valid/code/busy/overrun got %b/%0d/%b/%h required %b/%0d/%b/%h",
                             $time, got.v, got.c, got.b, got.ov, exp.v, exp.c, exp.b, exp.ov);
                end
                if (!rst && valid && ready) acc_log.push_back(int'(code));
            end
        end
    end

    initial begin : driver
        rst = 1'b1; e = 1'b0; req = 8'h00; ready = 1'b0;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);

        // Single request surfaces two edges later and is accepted at once.
        acc_log.delete();
        cyc(1'b0, 1'b1, 8'h10, 1'b1);
        idle(4, 1'b1);
        check_log("single", 1, 32'h4);

        cyc(1'b0, 1'b1, 8'hA5, 1'b1);
        idle(6, 1'b1);
        check_log("multi_hot", 4, 32'h7520);

        // Higher priority arrival must not disturb a stalled code.
        cyc(1'b0, 1'b1, 8'h02, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, 1'b1, 8'h80, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);
        check_log("backpressure", 2, 32'h17);

        cyc(1'b0, 1'b1, 8'h08, 1'b0);
        idle(1, 1'b0);
        cyc(1'b0, 1'b1, 8'h08, 1'b1);
        idle(2, 1'b0);
        cyc(1'b0, 1'b1, 8'h08, 1'b0);
        idle(3, 1'b1);
        check_log("set_over_clear", 2, 32'h33);

        cyc(1'b0, 1'b1, 8'h40, 1'b0);
        cyc(1'b0, 1'b0, 8'hFF, 1'b0);
        cyc(1'b0, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'hFF, 1'b1);
        check_log("enable_gate", 1, 32'h6);

        cyc(1'b0, 1'b1, 8'hF0, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, 1'b1, 8'h00, 1'b1);
        idle(4, 1'b1);
        check_log("reset_mid_op", 0, 32'h0);

        cyc(1'b0, 1'b1, 8'hFF, 1'b1);
        idle(10, 1'b1);
        check_log("all_ones", 8, 32'h76543210);

        for (int n = 0; n < 3000; n++) begin
            bit         r;
            bit         en;
            bit         rd;
            logic [7:0] rq;
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 9) < 8);
            rd = ($urandom_range(0, 9) < 6);
            rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cyc(r, en, rq, rd);
        end

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (state_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", state_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/encoder_83_req.md
Name: encoder_83_req

Overview:
- Registered 8-to-3 priority request encoder. It is the encode-side counterpart of the team's 3-to-8 select decoders.
- Collects one-hot or multi-hot request pulses on 8 lines into a pending register.
- Presents the highest-priority pending index as a 3-bit code through a valid/ready handshake.
- Clears each request when its code is accepted. Used as the request concentrator in front of decoder-driven select logic.

Parameters:
- N, 8, number of request lines (fixed at 8 for this revision; checked by elaboration assertion).
- W, 3, code width, equal to log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- e  input  1  enable; gates capture of new requests only.
- req  input  8  request pulses; bit i requests service for index i.
- code  output  3  encoded index of the granted request (registered).
- valid  output  1  code holds a pending request (registered).
- ready  input  1  consumer accepts code on the rising edge where valid && ready.
- overrun  output  8  one-cycle pulse per line: request arrived while that line was already pending.
- busy  output  1  combinational OR of pending bits and valid.

Behaviour:
- Reset (rst=1 at an edge): pending=0, valid=0, code=0, overrun=0. Reset mid-handshake drops all pending and presented requests; ready is ignored during reset.
- Capture: set = req & {8{e}}. ack = valid && ready. clr = one-hot(code) when ack, else 0.
- Pending update each edge: pending <= (pending & ~clr) | set.
- Set wins over clear on the same bit: a re-request on the index being acknowledged leaves that bit pending as a new request.
- Priority: fixed, index 7 highest, index 0 lowest, using standard 8-to-3 priority encoding.
- Presented vector: cand = pending & ~clr. Newly captured requests are not visible in cand until the following cycle.
- Output stage loads when (!valid || ack):
  - valid <= |cand;
  - code <= prio(cand) if cand is non-zero, otherwise code holds its value.
- Stability: while valid && !ready, code and valid do not change, even if a higher-priority request arrives.
- The presented bit remains set in pending until its ack.
- Latency: req at edge k sets pending; valid/code are visible after edge k+1. Minimum req-to-valid is 2 cycles.
- Throughput: with ready held at 1, one code is accepted per cycle, back-to-back, in descending index order of what is pending.
- Overrun: overrun[i] <= set[i] && pending[i] && !clr[i], registered as a one-cycle pulse. The request is merged, not counted; only one service occurs.
- e=0: req is ignored entirely, with no overrun. Pending requests and the handshake continue to drain normally.
- Empty: valid=0 and code holds its last value; code is don't-care for consumers when valid=0.
- All-ones request: the 8 codes drain 7,6,...,0 over 8 accepted cycles.

Decomposition:
- Shared package enc_pkg:
  - constants N=8 and W=3;
  - function prio8 (8-bit to 3-bit, highest index wins);
  - function onehot3 (3-bit to 8-bit).
- onehot3 is the same mapping the 3-to-8 decoders implement; they reuse it.
- One natural sub-module: prio_enc_8 (combinational priority encoder with an any-flag), instantiated once on cand.
- The top level holds the pending register, output stage and overrun logic.

Test Plan:
- Reset then single request: rst 2 cycles; req=8'b0001_0000 for 1 cycle with e=1, ready=1 -> valid rises 2 cycles later with code=4, is accepted that cycle, and valid=0 the next cycle; busy returns to 0.
- Multi-hot drain: req=8'b1010_0101 for 1 cycle, ready=1 -> codes 7,5,2,0 on 4 consecutive valid cycles, then valid=0.
- Backpressure stability: pending={1}, ready=0, code=1 valid; then req=8'h80 -> code stays 1 and valid stays 1 until ready=1; then code 1 is accepted, followed by code 7.
- Set-over-clear and overrun:
  - With code=3 presented and ready=1, assert req[3] -> bit 3 is re-pending and code 3 is presented again 2 cycles later; overrun[3]=0.
  - With ready=0, repeat req[3] -> overrun=8'h08 for exactly 1 cycle.
- Enable gating: e=0 with req=8'hFF -> no valid and no overrun. Pending bits set before e fell (e.g. bit 6) still drain with code=6.
- Reset mid-operation: pending=8'hF0, valid=1, ready=0; pulse rst -> after the edge valid=0, code=0, busy=0, and no codes are emitted afterward.
